rps_round_ctrl: RTL
===================

// Module: rps_round_ctrl
// PURPOSE
//  Upstream stage of the RPS scoring DUT. Collects one move per player over valid/ready,
//  drives the one-hot r/p/s buses and a simultaneous go1/go2 pulse, then tracks the DUT's
//  dut_busy handshake to close the round. Counts completed rounds, flags illegal moves and
//  flags DUT non-response.
// PARAMETERS
//  GO_HOLD       4    clk cycles go1/go2 stay high per round (>=1)
//  BUSY_TIMEOUT  64   clk cycles allowed from go rise to dut_busy=1 before timeout
//  CNT_W         16   width of round_cnt and illegal_cnt
// PORTS
//  clk          in   1      sole clock, all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  mv1_valid    in   1      player 1 move valid
//  mv1          in   2      player 1 move (move_t)
//  mv1_ready    out  1      player 1 slot can accept
//  mv2_valid    in   1      player 2 move valid
//  mv2          in   2      player 2 move (move_t)
//  mv2_ready    out  1      player 2 slot can accept
//  r1,p1,s1     out  1 ea   player 1 one-hot move to DUT
//  r2,p2,s2     out  1 ea   player 2 one-hot move to DUT
//  go1,go2      out  1 ea   round start to DUT; always driven identically
//  dut_busy     in   1      DUT busy flag
//  round_done   out  1      1-cycle pulse when a round closes normally
//  timeout      out  1      1-cycle pulse when BUSY_TIMEOUT expires
//  round_cnt    out  CNT_W  completed rounds, wraps at 2**CNT_W
//  illegal_cnt  out  CNT_W  MV_NONE moves received, saturates at all-ones
// BEHAVIOUR
//  - Reset: all outputs 0, both slots empty, state COLLECT; reset mid-round drops go and r/p/s the next edge.
//  - Encoding: MV_NONE=0, MV_ROCK=1, MV_PAPER=2, MV_SCISSORS=3. r/p/s = exactly one-hot or all 0.
//  - mvX_ready = (state==COLLECT) & slotX empty. Transfer on valid&ready; both players may transfer same cycle.
//  - A transfer of MV_NONE is consumed, increments illegal_cnt, and leaves the slot empty.
//  - FSM: COLLECT -> ISSUE when both slots full (checked on registered slot state).
//    ISSUE (1 cycle): r/p/s driven from slots; go low. -> GO.
//    GO: go1=go2=1 for GO_HOLD cycles, then low; busy-timer starts on first GO cycle. -> WAIT_BUSY after GO_HOLD, or directly when dut_busy seen.
//    WAIT_BUSY: on dut_busy=1 -> WAIT_DONE. On timer==BUSY_TIMEOUT -> timeout pulse, clear slots, r/p/s=0, -> COLLECT.
//    WAIT_DONE: on dut_busy 1->0 -> round_done pulse, round_cnt+1, clear slots, r/p/s=0, -> COLLECT.
//  - dut_busy seen during GO: go still completes GO_HOLD before release; state advances to WAIT_DONE once go drops.
//  - go low for >=2 cycles between rounds (ISSUE plus >=1 COLLECT cycle), so every round is a fresh rising edge.
//  - r/p/s held stable from ISSUE until round close, covering the DUT's post-edge sampling delay.
//  - Latency: last move accepted at edge N -> r/p/s valid after N+1 -> go high after N+2.
// CONFIGURATION
//  RPS_LFSR_PLAYER2_EN defined: player 2 is internal. mv2_valid/mv2 are ignored and mv2_ready is tied 0.
//   On entering COLLECT, slot 2 is loaded from a 16-bit LFSR (seed 16'hACE1 on rst) mapped to a nonzero move.
//   The LFSR advances one step per round.
//  Undefined: both players external, as above.
// STRUCTURE
//  rps_pkg: move_t enum, round FSM state enum, function move_to_onehot(move_t) -> {r,p,s}.
//  Sub-module rps_lfsr (16-bit Galois LFSR, step/seed, 2-bit nonzero move out), instantiated only under RPS_LFSR_PLAYER2_EN.
// TESTING
//  1. rst 3 cycles -> all outputs 0, mv1_ready=mv2_ready=1.
//  2. mv1=ROCK, mv2=SCISSORS same cycle; DUT model busy 3 cycles -> r1=1,s2=1.
//     go high 4 cycles starting 2 cycles later; round_done pulse; round_cnt=1.
//  3. mv1=PAPER first, mv2=ROCK 5 cycles later -> mv1_ready low meanwhile.
//     Go starts 2 cycles after mv2 accept.
//  4. mv1=MV_NONE -> illegal_cnt=1, mv1_ready stays 1, no go.
//  5. dut_busy never rises -> timeout pulse 64 cycles after go rise; slots cleared; round_cnt unchanged.
//  6. rst asserted in WAIT_DONE -> next cycle go=0, r/p/s=0, round_cnt=0.
//     Then 100 back-to-back rounds -> round_cnt=100, go rises exactly 100 times.

Source files
------------

// File: rtl/rps_pkg.sv
// rps_pkg: shared move/state types and the one-hot move decoder for the RPS round controller
package rps_pkg;
  typedef enum logic [1:0] {
    MV_NONE     = 2'd0,
    MV_ROCK     = 2'd1,
    MV_PAPER    = 2'd2,
    MV_SCISSORS = 2'd3
  } move_t;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_ISSUE,
    ST_GO,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  function automatic logic [2:0] move_to_onehot(move_t m);
    return m == MV_ROCK ? 3'b100 : m == MV_PAPER ? 3'b010 : m == MV_SCISSORS ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/rps_round_ctrl_if.sv
// rps_round_ctrl_if: player move handshakes plus the r/p/s, go and busy lines to the scoring DUT
interface rps_round_ctrl_if;
  logic           mv1_valid;
  rps_pkg::move_t mv1;
  logic           mv1_ready;
  logic           mv2_valid;
  rps_pkg::move_t mv2;
  logic           mv2_ready;
  logic           r1, p1, s1;
  logic           r2, p2, s2;
  logic           go1, go2;
  logic           dut_busy;

  modport master (
    output mv1_valid, mv1, mv2_valid, mv2, dut_busy,
    input  mv1_ready, mv2_ready, r1, p1, s1, r2, p2, s2, go1, go2
  );

  modport slave (
    input  mv1_valid, mv1, mv2_valid, mv2, dut_busy,
    output mv1_ready, mv2_ready, r1, p1, s1, r2, p2, s2, go1, go2
  );
endinterface

// File: rtl/rps_lfsr.sv
// rps_lfsr: 16-bit Galois LFSR (seed 16'hACE1) supplying a nonzero move for the internal player 2
module rps_lfsr
  import rps_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  step,
  output move_t mv
);
  logic [15:0] lfsr_q, lfsr_d;

  // advance one Galois step when asked; low bits map to a move, zero folded onto rock
  always_comb begin
    lfsr_d = !step ? lfsr_q : lfsr_q[0] ? (lfsr_q >> 1) ^ 16'hB400 : lfsr_q >> 1;
    mv     = lfsr_q[1:0] == 2'd0 ? MV_ROCK : move_t'(lfsr_q[1:0]);
  end

  // state register with seed load on reset
  always_ff @(posedge clk) lfsr_q <= rst ? 16'hACE1 : lfsr_d;
endmodule

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl: collects two moves, drives r/p/s and go to the scoring DUT, closes on busy handshake; RPS_LFSR_PLAYER2_EN makes player 2 internal
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int GO_HOLD      = 4,
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  rps_round_ctrl_if.slave  bus,
  output logic             round_done,
  output logic             timeout,
  output logic [CNT_W-1:0] round_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int HW = $clog2(GO_HOLD + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t           state_q, state_d;
  move_t            slot1_q, slot1_d, slot2_q, slot2_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             busy_seen_q, busy_seen_d;
  logic             round_done_q, round_done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             x1, x2, hold_end, tmo, done, close;
  logic [1:0]       ill_inc;
  logic [CNT_W:0]   ill_sum;

`ifdef RPS_LFSR_PLAYER2_EN
  move_t lfsr_mv;
  logic  lfsr_step;
  assign lfsr_step = state_q == ST_COLLECT && slot2_q == MV_NONE;
  rps_lfsr u_lfsr (.clk(clk), .rst(rst), .step(lfsr_step), .mv(lfsr_mv));
`endif

  // transfer strobes and round-closing conditions
  always_comb begin
    x1       = bus.mv1_valid & bus.mv1_ready;
    x2       = bus.mv2_valid & bus.mv2_ready;
    hold_end = state_q == ST_GO && hold_q == HW'(GO_HOLD - 1);
    tmo      = state_q == ST_WAIT_BUSY && !bus.dut_busy && tmr_q == TW'(BUSY_TIMEOUT - 1);
    done     = state_q == ST_WAIT_DONE && !bus.dut_busy;
    close    = tmo | done;
  end

  // round FSM next state; busy seen during go still waits out the full hold
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT:   state_d = slot1_q != MV_NONE && slot2_q != MV_NONE ? ST_ISSUE : ST_COLLECT;
      ST_ISSUE:     state_d = ST_GO;
      ST_GO:        state_d = !hold_end ? ST_GO : (busy_seen_q | bus.dut_busy) ? ST_WAIT_DONE : ST_WAIT_BUSY;
      ST_WAIT_BUSY: state_d = bus.dut_busy ? ST_WAIT_DONE : tmo ? ST_COLLECT : ST_WAIT_BUSY;
      ST_WAIT_DONE: state_d = done ? ST_COLLECT : ST_WAIT_DONE;
      default:      state_d = ST_COLLECT;
    endcase
  end

  // slots, timers, pulses and counters; illegal moves are consumed without filling a slot
  always_comb begin
    slot1_d       = close ? MV_NONE : x1 ? bus.mv1 : slot1_q;
`ifdef RPS_LFSR_PLAYER2_EN
    slot2_d       = close ? MV_NONE : lfsr_step ? lfsr_mv : slot2_q;
`else
    slot2_d       = close ? MV_NONE : x2 ? bus.mv2 : slot2_q;
`endif
    hold_d        = state_q == ST_GO ? hold_q + 1'b1 : '0;
    tmr_d         = (state_q == ST_GO || state_q == ST_WAIT_BUSY) ? tmr_q + 1'b1 : '0;
    busy_seen_d   = state_q == ST_GO && (busy_seen_q || bus.dut_busy);
    round_done_d  = done;
    timeout_d     = tmo;
    round_cnt_d   = round_cnt_q + CNT_W'(done);
    ill_inc       = {1'b0, x1 && bus.mv1 == MV_NONE} + {1'b0, x2 && bus.mv2 == MV_NONE};
    ill_sum       = {1'b0, illegal_cnt_q} + (CNT_W + 1)'(ill_inc);
    illegal_cnt_d = ill_sum[CNT_W] ? '1 : ill_sum[CNT_W-1:0];
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_COLLECT;
      slot1_q       <= MV_NONE;
      slot2_q       <= MV_NONE;
      hold_q        <= '0;
      tmr_q         <= '0;
      busy_seen_q   <= 1'b0;
      round_done_q  <= 1'b0;
      timeout_q     <= 1'b0;
      round_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      slot1_q       <= slot1_d;
      slot2_q       <= slot2_d;
      hold_q        <= hold_d;
      tmr_q         <= tmr_d;
      busy_seen_q   <= busy_seen_d;
      round_done_q  <= round_done_d;
      timeout_q     <= timeout_d;
      round_cnt_q   <= round_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // outputs: r/p/s held from ISSUE until close, go only in GO, ready only for empty slots in COLLECT
  always_comb begin
    {bus.r1, bus.p1, bus.s1} = state_q != ST_COLLECT ? move_to_onehot(slot1_q) : 3'b000;
    {bus.r2, bus.p2, bus.s2} = state_q != ST_COLLECT ? move_to_onehot(slot2_q) : 3'b000;
    bus.go1                  = state_q == ST_GO;
    bus.go2                  = state_q == ST_GO;
    bus.mv1_ready            = state_q == ST_COLLECT && slot1_q == MV_NONE;
`ifdef RPS_LFSR_PLAYER2_EN
    bus.mv2_ready            = 1'b0;
`else
    bus.mv2_ready            = state_q == ST_COLLECT && slot2_q == MV_NONE;
`endif
  end

  assign round_done  = round_done_q;
  assign timeout     = timeout_q;
  assign round_cnt   = round_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
endmodule
